// File: rtl/rd_engine.sv
// rd_engine: issues one AXI4 INCR read burst per start strobe and reports its beats and status.
// Define RD_ENGINE_RETRY_EN to re-issue a failed burst up to MAX_RETRY times before reporting an error.
`timescale 1ns/1ps
module rd_engine #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [LEN_WIDTH-1:0]  read_len,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_data_valid,
    output logic                  end_of_read,
    output logic                  read_error,
    output logic                  m_axi_ARVALID,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [LEN_WIDTH-1:0]  m_axi_ARLEN,
    input  logic                  m_axi_ARREADY,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    output logic [1:0]            m_axi_ARLOCK,
    output logic [3:0]            m_axi_ARCACHE,
    output logic [2:0]            m_axi_ARPROT,
    output logic [3:0]            m_axi_ARQOS,
    output logic [3:0]            m_axi_ARREGION,
    input  logic                  m_axi_RVALID,
    input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
    input  logic [1:0]            m_axi_RRESP,
    input  logic                  m_axi_RLAST,
    input  logic [ID_WIDTH-1:0]   m_axi_RID,
    output logic                  m_axi_RREADY
);
    localparam int CW = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_ADDR  = 3'd1,
        RD_DATA  = 3'd2,
        RD_RETRY = 3'd3,
        RD_END   = 3'd4
    } rd_state_t;

    rd_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [LEN_WIDTH-1:0]  arlen_q;
    logic [CW-1:0]         beat_cnt, beat_inc, len_beats;
    logic                  err_flag, beat_fire, last_fire, beat_err, err_final, go_retry;
    logic                  unused_ok;

    assign m_axi_ARVALID  = (state == RD_ADDR);
    assign m_axi_RREADY   = (state == RD_DATA);
    assign m_axi_ARADDR   = araddr_q;
    assign m_axi_ARLEN    = arlen_q;
    assign m_axi_ARID     = '0;
    assign m_axi_ARSIZE   = (DATA_WIDTH == 256) ? 3'b101 : 3'b110;
    assign m_axi_ARBURST  = 2'b01;
    assign m_axi_ARLOCK   = 2'b00;
    assign m_axi_ARCACHE  = 4'b0000;
    assign m_axi_ARPROT   = 3'b010;
    assign m_axi_ARQOS    = 4'b0000;
    assign m_axi_ARREGION = 4'b0000;

    assign beat_fire = m_axi_RVALID && m_axi_RREADY;
    assign last_fire = beat_fire && m_axi_RLAST;
    assign len_beats = {1'b0, arlen_q} + CW'(1);
    assign beat_inc  = (&beat_cnt) ? beat_cnt : beat_cnt + CW'(1);
    // Overrun beats and an early or late RLAST are treated like a slave error.
    assign beat_err  = beat_fire && (m_axi_RRESP[1] || (beat_inc > len_beats) ||
                                     (m_axi_RLAST && (beat_inc != len_beats)));
    assign err_final = err_flag || beat_err;

`ifdef RD_ENGINE_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;

    assign go_retry  = err_final && (retry_cnt < RW'(MAX_RETRY));
    assign unused_ok = &{1'b0, m_axi_RID, m_axi_RRESP[0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retry_cnt <= '0;
        end else if (state == RD_IDLE && start) begin
            retry_cnt <= '0;
        end else if (state == RD_RETRY) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end
`else
    assign go_retry  = 1'b0;
    assign unused_ok = &{1'b0, m_axi_RID, m_axi_RRESP[0], MAX_RETRY[0]};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = RD_IDLE;
        case (state)
            RD_IDLE:  state_next = start ? RD_ADDR : RD_IDLE;
            RD_ADDR:  state_next = m_axi_ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA: begin
                if (last_fire) begin
                    state_next = go_retry ? RD_RETRY : RD_END;
                end else begin
                    state_next = RD_DATA;
                end
            end
`ifdef RD_ENGINE_RETRY_EN
            RD_RETRY: state_next = RD_ADDR;
`endif
            RD_END:   state_next = RD_IDLE;
            default:  state_next = RD_IDLE;
        endcase
    end

    // The status pulse is registered on entry to RD_END so it lines up with the final data pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            araddr_q        <= '0;
            arlen_q         <= '0;
            beat_cnt        <= '0;
            err_flag        <= 1'b0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            end_of_read     <= 1'b0;
            read_error      <= 1'b0;
        end else begin
            read_data_valid <= beat_fire;
            end_of_read     <= (state_next == RD_END);
            read_error      <= (state_next == RD_END) && err_final;
            if (beat_fire) begin
                read_data <= m_axi_RDATA;
            end
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        araddr_q <= read_addr;
                        arlen_q  <= read_len;
                        beat_cnt <= '0;
                        err_flag <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_inc;
                    end
                    if (beat_err) begin
                        err_flag <= 1'b1;
                    end
                end
`ifdef RD_ENGINE_RETRY_EN
                RD_RETRY: begin
                    beat_cnt <= '0;
                    err_flag <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rd_engine.sv
// tb_rd_engine: directed bench for rd_engine with a burst-level scoreboard model of the read engine.
// Expectations follow RD_ENGINE_RETRY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rd_engine;
    localparam int AW = 33;
    localparam int DW = 256;
    localparam int IW = 6;
    localparam int LW = 8;
    localparam int MR = 3;
`ifdef RD_ENGINE_RETRY_EN
    localparam int ATTEMPTS = MR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] read_addr = '0;
    logic [LW-1:0] read_len = '0;
    logic [DW-1:0] read_data;
    logic          read_data_valid, end_of_read, read_error;
    logic          m_axi_ARVALID;
    logic [AW-1:0] m_axi_ARADDR;
    logic [IW-1:0] m_axi_ARID;
    logic [LW-1:0] m_axi_ARLEN;
    logic          m_axi_ARREADY = 1'b0;
    logic [2:0]    m_axi_ARSIZE, m_axi_ARPROT;
    logic [1:0]    m_axi_ARBURST, m_axi_ARLOCK;
    logic [3:0]    m_axi_ARCACHE, m_axi_ARQOS, m_axi_ARREGION;
    logic          m_axi_RVALID = 1'b0;
    logic [DW-1:0] m_axi_RDATA = '0;
    logic [1:0]    m_axi_RRESP = 2'b00;
    logic          m_axi_RLAST = 1'b0;
    logic [IW-1:0] m_axi_RID = 6'h2a;
    logic          m_axi_RREADY;

    always #5 clk = ~clk;

    rd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_RETRY(MR)) dut (
        .clk(clk), .resetn(resetn), .start(start), .read_addr(read_addr), .read_len(read_len),
        .read_data(read_data), .read_data_valid(read_data_valid), .end_of_read(end_of_read),
        .read_error(read_error), .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARADDR(m_axi_ARADDR),
        .m_axi_ARID(m_axi_ARID), .m_axi_ARLEN(m_axi_ARLEN), .m_axi_ARREADY(m_axi_ARREADY),
        .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST), .m_axi_ARLOCK(m_axi_ARLOCK),
        .m_axi_ARCACHE(m_axi_ARCACHE), .m_axi_ARPROT(m_axi_ARPROT), .m_axi_ARQOS(m_axi_ARQOS),
        .m_axi_ARREGION(m_axi_ARREGION), .m_axi_RVALID(m_axi_RVALID), .m_axi_RDATA(m_axi_RDATA),
        .m_axi_RRESP(m_axi_RRESP), .m_axi_RLAST(m_axi_RLAST), .m_axi_RID(m_axi_RID),
        .m_axi_RREADY(m_axi_RREADY)
    );

    int            n_checks = 0;
    int            n_fail = 0;
    int            cur_len = 0;
    int            m_beats = 0;
    int            m_ar_cnt = 0;
    int            eor_seen = 0;
    int            rdv_seen = 0;
    logic          m_err = 1'b0;
    logic          m_busy = 1'b0;
    logic          exp_rdv = 1'b0;
    logic          exp_eor = 1'b0;
    logic          exp_err = 1'b0;
    logic          last_err_seen = 1'b0;
    logic          check_en = 1'b0;
    logic [DW-1:0] exp_data = '0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, DW'(act), DW'(exp));
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checkOutput(name, DW'(act), DW'(exp));
    endtask

    function automatic logic [DW-1:0] beatData(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {8{w}};
    endfunction

    // Burst-level model: a burst fails on any error response or a beat count that differs from len+1.
    always @(posedge clk) begin
        if (!resetn) begin
            exp_rdv  <= 1'b0;
            exp_eor  <= 1'b0;
            exp_err  <= 1'b0;
            m_beats  <= 0;
            m_err    <= 1'b0;
            m_busy   <= 1'b0;
            m_ar_cnt <= 0;
        end else begin
            exp_rdv <= m_axi_RVALID && m_axi_RREADY;
            exp_eor <= 1'b0;
            exp_err <= 1'b0;
            if (start && !m_busy) begin
                m_busy   <= 1'b1;
                m_ar_cnt <= 0;
            end
            if (m_axi_ARVALID && m_axi_ARREADY) begin
                m_ar_cnt <= m_ar_cnt + 1;
                m_beats  <= 0;
                m_err    <= 1'b0;
            end
            if (m_axi_RVALID && m_axi_RREADY) begin
                exp_data <= m_axi_RDATA;
                m_beats  <= m_beats + 1;
                m_err    <= m_err | m_axi_RRESP[1];
                if (m_axi_RLAST) begin
                    if (!((m_err | m_axi_RRESP[1] | (m_beats + 1 != cur_len + 1)) && (m_ar_cnt < ATTEMPTS))) begin
                        exp_eor <= 1'b1;
                        exp_err <= m_err | m_axi_RRESP[1] | (m_beats + 1 != cur_len + 1);
                        m_busy  <= 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkBit("read_data_valid", read_data_valid, exp_rdv);
            if (exp_rdv) checkOutput("read_data", read_data, exp_data);
            checkBit("end_of_read", end_of_read, exp_eor);
            if (exp_eor) checkBit("read_error", read_error, exp_err);
            if (end_of_read) begin
                eor_seen++;
                last_err_seen = read_error;
            end
            if (read_data_valid) rdv_seen++;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input int len);
        @(negedge clk);
        checkBit("arvalid_idle", m_axi_ARVALID, 1'b0);
        start     = 1'b1;
        read_addr = addr;
        read_len  = LW'(len);
        cur_len   = len;
        @(negedge clk);
        start     = 1'b0;
        read_addr = '1;
        read_len  = '1;
        checkBit("arvalid_n_plus_1", m_axi_ARVALID, 1'b1);
        checkOutput("araddr", DW'(m_axi_ARADDR), DW'(addr));
        checkInt("arlen", int'(m_axi_ARLEN), len);
        checkInt("arburst", int'(m_axi_ARBURST), 1);
    endtask

    task automatic waitAr(input logic [AW-1:0] addr, input int len, input int delay, input bit poke);
        int t = 0;
        int hi = 0;
        while (m_axi_ARVALID !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkBit("arvalid_seen", m_axi_ARVALID, 1'b1);
        for (int i = 0; i < delay; i++) begin
            start = poke && (i == 0);
            if (poke && i == 0) read_addr = 33'h1_FFFF_0000;
            if (m_axi_ARVALID && m_axi_ARADDR == addr && m_axi_ARLEN == LW'(len)) hi++;
            @(negedge clk);
        end
        start = 1'b0;
        if (m_axi_ARVALID && m_axi_ARADDR == addr && m_axi_ARLEN == LW'(len)) hi++;
        m_axi_ARREADY = 1'b1;
        @(negedge clk);
        m_axi_ARREADY = 1'b0;
        checkBit("arvalid_drop", m_axi_ARVALID, 1'b0);
        checkInt("ar_stable_cycles", hi, delay + 1);
    endtask

    task automatic sendBeat(input logic [DW-1:0] d, input logic [1:0] resp, input logic last, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = d;
        m_axi_RRESP  = resp;
        m_axi_RLAST  = last;
        do begin
            @(posedge clk);
            t++;
        end while (m_axi_RREADY !== 1'b1 && t < 50);
        if (t >= 50) checkBit("rready_timeout", m_axi_RREADY, 1'b1);
        @(negedge clk);
        m_axi_RVALID = 1'b0;
        m_axi_RLAST  = 1'b0;
        m_axi_RRESP  = 2'b00;
        if (last) checkBit("rready_after_last", m_axi_RREADY, 1'b0);
    endtask

    task automatic checkBurst(input string tag, input int eor0, input int exp_hs, input logic exp_e);
        settle(3);
        checkInt({tag, "_eor_count"}, eor_seen - eor0, 1);
        checkInt({tag, "_ar_handshakes"}, m_ar_cnt, exp_hs);
        checkBit({tag, "_read_error"}, last_err_seen, exp_e);
    endtask

    initial begin
        int eor0;
        int rdv0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkBit("rst_arvalid", m_axi_ARVALID, 1'b0);
        checkBit("rst_rready", m_axi_RREADY, 1'b0);
        checkBit("rst_rdv", read_data_valid, 1'b0);
        checkBit("rst_eor", end_of_read, 1'b0);
        checkBit("rst_err", read_error, 1'b0);
        checkOutput("rst_read_data", read_data, '0);
        checkInt("arsize", int'(m_axi_ARSIZE), 5);
        checkInt("arprot", int'(m_axi_ARPROT), 2);
        checkInt("ar_zero_sideband", int'({m_axi_ARID, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARQOS, m_axi_ARREGION}), 0);
        resetn   = 1'b1;
        check_en = 1'b1;

        $display("[TB] single beat burst");
        eor0 = eor_seen;
        applyStimulus(33'h1000, 0);
        waitAr(33'h1000, 0, 0, 1'b0);
        sendBeat({32{8'hA5}}, 2'b00, 1'b1, 0);
        checkOutput("t1_data", read_data, {32{8'hA5}});
        checkBurst("t1", eor0, 1, 1'b0);

        $display("[TB] four beats, slow ARREADY, gapped RVALID");
        eor0 = eor_seen;
        rdv0 = rdv_seen;
        applyStimulus(33'h1_2340_0040, 3);
        waitAr(33'h1_2340_0040, 3, 5, 1'b1);
        sendBeat(beatData(0), 2'b00, 1'b0, 2);
        sendBeat(beatData(1), 2'b01, 1'b0, 0);
        sendBeat(beatData(2), 2'b00, 1'b0, 1);
        sendBeat(beatData(3), 2'b00, 1'b1, 3);
        checkOutput("t2_last_data", read_data, beatData(3));
        checkBurst("t2", eor0, 1, 1'b0);
        checkInt("t2_rdv_count", rdv_seen - rdv0, 4);

        $display("[TB] slave error on first beat");
        eor0 = eor_seen;
        applyStimulus(33'h1000, 1);
        waitAr(33'h1000, 1, 0, 1'b0);
        sendBeat(beatData(10), 2'b10, 1'b0, 0);
        sendBeat(beatData(11), 2'b00, 1'b1, 0);
`ifdef RD_ENGINE_RETRY_EN
        waitAr(33'h1000, 1, 0, 1'b0);
        sendBeat(beatData(12), 2'b00, 1'b0, 0);
        sendBeat(beatData(13), 2'b00, 1'b1, 0);
        checkBurst("t3", eor0, 2, 1'b0);
`else
        checkBurst("t3", eor0, 1, 1'b1);
`endif

        $display("[TB] decode error on every attempt");
        eor0 = eor_seen;
        applyStimulus(33'h2000, 0);
        for (int a = 0; a < ATTEMPTS; a++) begin
            waitAr(33'h2000, 0, 0, 1'b0);
            sendBeat(beatData(20 + a), 2'b11, 1'b1, 0);
        end
        checkBurst("t4", eor0, ATTEMPTS, 1'b1);

        $display("[TB] early RLAST");
        eor0 = eor_seen;
        applyStimulus(33'h4000, 3);
        for (int a = 0; a < ATTEMPTS; a++) begin
            waitAr(33'h4000, 3, 0, 1'b0);
            sendBeat(beatData(30), 2'b00, 1'b0, 0);
            sendBeat(beatData(31), 2'b00, 1'b0, 1);
            sendBeat(beatData(32), 2'b00, 1'b1, 0);
        end
        checkBurst("t5", eor0, ATTEMPTS, 1'b1);

        $display("[TB] overrun beats before RLAST");
        eor0 = eor_seen;
        applyStimulus(33'h5000, 1);
        for (int a = 0; a < ATTEMPTS; a++) begin
            waitAr(33'h5000, 1, 0, 1'b0);
            sendBeat(beatData(40), 2'b00, 1'b0, 0);
            sendBeat(beatData(41), 2'b00, 1'b0, 0);
            sendBeat(beatData(42), 2'b00, 1'b1, 0);
        end
        checkBurst("t6", eor0, ATTEMPTS, 1'b1);

        $display("[TB] maximum length burst");
        eor0 = eor_seen;
        rdv0 = rdv_seen;
        applyStimulus(33'h1_0000_0000, 255);
        waitAr(33'h1_0000_0000, 255, 0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            sendBeat(beatData(i), 2'b00, (i == 255), 0);
        end
        checkOutput("t7_last_data", read_data, beatData(255));
        checkBurst("t7", eor0, 1, 1'b0);
        checkInt("t7_rdv_count", rdv_seen - rdv0, 256);

        $display("[TB] reset during data phase");
        eor0 = eor_seen;
        applyStimulus(33'h3000, 3);
        waitAr(33'h3000, 3, 0, 1'b0);
        sendBeat(beatData(50), 2'b00, 1'b0, 0);
        sendBeat(beatData(51), 2'b00, 1'b0, 0);
        resetn = 1'b0;
        @(negedge clk);
        checkBit("t8_arvalid", m_axi_ARVALID, 1'b0);
        checkBit("t8_rready", m_axi_RREADY, 1'b0);
        checkOutput("t8_read_data", read_data, '0);
        resetn = 1'b1;
        settle(5);
        checkInt("t8_eor_count", eor_seen - eor0, 0);

        $display("[TB] recovery after reset");
        eor0 = eor_seen;
        applyStimulus(33'h6000, 0);
        waitAr(33'h6000, 0, 2, 1'b0);
        sendBeat(beatData(60), 2'b01, 1'b1, 1);
        checkBurst("t9", eor0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
